// File: rtl/bpm_mux_pkg.sv
// Shared types and helpers for the N-link BPM readback mux.
// Holds the arbiter mode codes, the arbiter state encoding and the round-robin pick.
package bpm_mux_pkg;

  localparam logic ARB_MODE_DRAIN  = 1'b0;
  localparam logic ARB_MODE_PACKET = 1'b1;

  localparam int unsigned MAX_NCH = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // First requester found scanning from last+1 with wrap-around over nch channels.
  function automatic logic [2:0] rr_pick(input logic [MAX_NCH-1:0] req,
                                         input logic [2:0]         last,
                                         input int unsigned        nch);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_NCH; i++) begin
      if (i <= nch) begin
        idx = (32'(last) + i) % nch;
        if (!found && req[idx[2:0]]) begin
          pick  = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bpm_mux_fifo.sv
// Per-link FWFT FIFO with packet-drop on overflow; head visible the cycle after a push.
// No input backpressure: a beat arriving while full is dropped with the rest of its packet.
module bpm_mux_fifo #(
  parameter int W     = 113,
  parameter int DEPTH = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_pop,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          drop;
  logic          full;
  logic          wr_last;
  logic          push;
  logic          pop;

  assign full    = (cnt == CNT_FULL);
  assign wr_last = wr_dat[W-1];
  assign push    = wr_vld && !drop && !full;
  assign pop     = rd_pop && rd_vld;
  assign ovf     = wr_vld && !drop && full;
  assign rd_vld  = (cnt != '0);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      drop   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (!push && pop) begin
        cnt <= cnt - CW'(1);
      end
      // Fullness is judged before any same-cycle pop; TLAST always ends a drop.
      if (wr_vld) begin
        drop <= (drop || full) && !wr_last;
      end
    end
  end

endmodule

// File: rtl/bpm_links_mux_rr.sv
// Packet-aware round-robin mux of NCH BPM links onto one AXI-Stream master, TUSER = source.
// Output is combinational from the granted FIFO head; one bubble cycle per grant switch.
// M_AXIS_TREADY low holds the head beat; input links are never stalled, overflow drops.
module bpm_links_mux_rr
  import bpm_mux_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 112,
  parameter int DEPTH = 40,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [NCH-1:0]    S_AXIS_TVALID,
  input  logic [NCH*DW-1:0] S_AXIS_TDATA,
  input  logic [NCH-1:0]    S_AXIS_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [DW-1:0]     M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  output logic [CHW-1:0]    M_AXIS_TUSER,
  input  logic              ARB_MODE,
  input  logic [NCH-1:0]    ARB_REQ_SUPPRESS,
  output logic [NCH-1:0]    OVERFLOW,
  input  logic [NCH-1:0]    OVERFLOW_CLEAR
);

  arb_state_t     state;
  logic [CHW-1:0] grant;
  logic [CHW-1:0] last_grant;
  logic           mode_q;
  logic           seen_last;

  logic [NCH-1:0] fifo_vld;
  logic [NCH-1:0] fifo_pop;
  logic [NCH-1:0] fifo_ovf;
  logic [NCH-1:0] eligible;
  logic [DW:0]    fifo_head [NCH];
  logic [DW:0]    head_sel;
  logic           beat_xfer;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_link
    bpm_mux_fifo #(
      .W     (DW + 1),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (ACLK),
      .rst_n  (ARESETN),
      .wr_vld (S_AXIS_TVALID[gi]),
      .wr_dat ({S_AXIS_TLAST[gi], S_AXIS_TDATA[gi*DW +: DW]}),
      .rd_pop (fifo_pop[gi]),
      .rd_vld (fifo_vld[gi]),
      .rd_dat (fifo_head[gi]),
      .ovf    (fifo_ovf[gi])
    );
    assign fifo_pop[gi] = beat_xfer && (grant == CHW'(gi));
  end

  assign head_sel      = fifo_head[grant];
  assign M_AXIS_TVALID = (state == ARB_GRANT) && fifo_vld[grant];
  assign beat_xfer     = M_AXIS_TVALID && M_AXIS_TREADY;
  assign M_AXIS_TDATA  = head_sel[DW-1:0];
  assign M_AXIS_TLAST  = M_AXIS_TVALID && head_sel[DW];
  assign M_AXIS_TUSER  = grant;
  assign eligible      = fifo_vld & ~ARB_REQ_SUPPRESS;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= CHW'(NCH - 1);
      mode_q     <= ARB_MODE_PACKET;
      seen_last  <= 1'b1;
      OVERFLOW   <= '0;
    end else begin
      OVERFLOW <= (OVERFLOW & ~OVERFLOW_CLEAR) | fifo_ovf;
      case (state)
        ARB_IDLE: begin
          // Mode is latched here so a mid-packet mode change cannot split a packet.
          if (|eligible) begin
            state     <= ARB_GRANT;
            grant     <= CHW'(rr_pick(8'(eligible), 3'(last_grant), NCH));
            mode_q    <= ARB_MODE;
            seen_last <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (beat_xfer) begin
            seen_last <= head_sel[DW];
            if (mode_q == ARB_MODE_PACKET && head_sel[DW]) begin
              state      <= ARB_IDLE;
              last_grant <= grant;
            end
          end else if (mode_q == ARB_MODE_DRAIN && !fifo_vld[grant] && seen_last) begin
            state      <= ARB_IDLE;
            last_grant <= grant;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpm_links_mux_rr.sv
// Directed bench for bpm_links_mux_rr (NCH=3, DW=16, DEPTH=8) against a queue-level model.
module tb_bpm_links_mux_rr;

  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int DEP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           aresetn;
  logic [NCH-1:0] s_tvalid;
  logic [NCH-1:0] s_tlast;
  logic [DW-1:0]  in_dat [NCH];
  logic [NCH*DW-1:0] s_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic [DW-1:0]  m_tdata;
  logic           m_tlast;
  logic [1:0]     m_tuser;
  logic           arb_mode;
  logic [NCH-1:0] suppress;
  logic [NCH-1:0] ovf;
  logic [NCH-1:0] ovf_clr;

  assign s_tdata = {in_dat[2], in_dat[1], in_dat[0]};

  bpm_links_mux_rr #(.NCH(NCH), .DW(DW), .DEPTH(DEP)) dut (
    .ACLK             (clk),
    .ARESETN          (aresetn),
    .S_AXIS_TVALID    (s_tvalid),
    .S_AXIS_TDATA     (s_tdata),
    .S_AXIS_TLAST     (s_tlast),
    .M_AXIS_TVALID    (m_tvalid),
    .M_AXIS_TREADY    (m_tready),
    .M_AXIS_TDATA     (m_tdata),
    .M_AXIS_TLAST     (m_tlast),
    .M_AXIS_TUSER     (m_tuser),
    .ARB_MODE         (arb_mode),
    .ARB_REQ_SUPPRESS (suppress),
    .OVERFLOW         (ovf),
    .OVERFLOW_CLEAR   (ovf_clr)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- queue-level reference model ----------------
  typedef struct packed {
    logic          last;
    logic [DW-1:0] dat;
  } beat_t;

  beat_t          mq [NCH][$];
  int             mg;        // granted channel, -1 when idle
  int             mlast;
  logic           mmode;
  logic           mseen;
  logic [NCH-1:0] mdrop;
  logic [NCH-1:0] movf;
  int             sz [NCH];
  beat_t          b;
  logic           found;
  logic           newovf;

  always @(posedge clk) begin
    cyc++;
    if (!aresetn) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      mg = -1; mlast = NCH - 1; mmode = 1'b1; mseen = 1'b1;
      mdrop = '0; movf = '0;
    end else begin
      for (int c = 0; c < NCH; c++) sz[c] = mq[c].size();
      if (mg < 0) begin
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
          if (!found && sz[(mlast + i) % NCH] > 0 && !suppress[(mlast + i) % NCH]) begin
            found = 1'b1;
            mg = (mlast + i) % NCH;
          end
        end
        if (found) begin mmode = arb_mode; mseen = 1'b1; end
      end else if (sz[mg] > 0 && m_tready) begin
        b = mq[mg].pop_front();
        mseen = b.last;
        if (mmode && b.last) begin mlast = mg; mg = -1; end
      end else if (!mmode && sz[mg] == 0 && mseen) begin
        mlast = mg; mg = -1;
      end
      for (int c = 0; c < NCH; c++) begin
        newovf = 1'b0;
        if (s_tvalid[c]) begin
          if (mdrop[c]) begin
            if (s_tlast[c]) mdrop[c] = 1'b0;
          end else if (sz[c] >= DEP) begin
            newovf = 1'b1;
            mdrop[c] = !s_tlast[c];
          end else begin
            mq[c].push_back({s_tlast[c], in_dat[c]});
          end
        end
        movf[c] = (movf[c] & !ovf_clr[c]) | newovf;
      end
    end
  end

  // ---------------- compare process + handshake log ----------------
  typedef struct {
    int            cy;
    int            ch;
    logic [DW-1:0] dat;
    logic          last;
  } hs_t;
  hs_t  hs [$];
  logic ev;
  beat_t eh;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      ev = 1'b0;
      eh = '0;
      if (mg >= 0) begin
        if (mq[mg].size() > 0) begin ev = 1'b1; eh = mq[mg][0]; end
      end
      chk("tvalid", m_tvalid, ev);
      if (ev) begin
        chk("tdata", m_tdata, eh.dat);
        chk("tlast", m_tlast, eh.last);
        chk("tuser", m_tuser, mg);
      end
      chk("overflow", ovf, movf);
      if (m_tvalid && m_tready) hs.push_back('{cyc, int'(m_tuser), m_tdata, m_tlast});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = '0; s_tlast = '0;
    repeat (n) tick();
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l,
                       input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    s_tvalid = v; s_tlast = l;
    in_dat[0] = d0; in_dat[1] = d1; in_dat[2] = d2;
    tick();
  endtask

  task automatic chk_hs(input int idx, input int ch, input logic [15:0] d, input logic l);
    if (idx < hs.size()) begin
      chk($sformatf("hs%0d_ch", idx), hs[idx].ch, ch);
      chk($sformatf("hs%0d_dat", idx), hs[idx].dat, d);
      chk($sformatf("hs%0d_last", idx), hs[idx].last, l);
    end else begin
      chk($sformatf("hs%0d_present", idx), hs.size(), idx + 1);
    end
  endtask

  task automatic chk_gap(input string nm, input int a, input int bb, input int gap);
    if (bb < hs.size()) chk(nm, hs[bb].cy - hs[a].cy, gap);
    else chk({nm, "_present"}, hs.size(), bb + 1);
  endtask

  initial begin
    aresetn = 1'b0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    arb_mode = 1'b1; suppress = '0; ovf_clr = '0;
    for (int c = 0; c < NCH; c++) in_dat[c] = '0;
    repeat (2) tick();
    aresetn = 1'b1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_ovf", ovf, 0);
    idle(2);

    // 1: packet mode, ch0 and ch2 5-beat packets together
    hs.delete();
    for (int i = 0; i < 5; i++)
      drive(3'b101, (i == 4) ? 3'b101 : 3'b000, 16'h0000 + 16'(i), 16'h0, 16'h2000 + 16'(i));
    idle(16);
    chk("t1_count", hs.size(), 10);
    for (int i = 0; i < 5; i++) chk_hs(i, 0, 16'h0000 + 16'(i), i == 4);
    for (int i = 0; i < 5; i++) chk_hs(5 + i, 2, 16'h2000 + 16'(i), i == 4);
    chk_gap("t1_bubble", 4, 5, 2);

    // 2: drain mode, two ch0 packets then ch1
    hs.delete();
    arb_mode = 1'b0; m_tready = 1'b0;
    for (int i = 0; i < 3; i++)
      drive(3'b011, (i == 2) ? 3'b011 : 3'b000, 16'h0100 + 16'(i), 16'h1100 + 16'(i), 16'h0);
    for (int i = 0; i < 2; i++)
      drive(3'b001, (i == 1) ? 3'b001 : 3'b000, 16'h0200 + 16'(i), 16'h0, 16'h0);
    s_tvalid = '0; m_tready = 1'b1;
    idle(20);
    chk("t2_count", hs.size(), 8);
    for (int i = 0; i < 3; i++) chk_hs(i, 0, 16'h0100 + 16'(i), i == 2);
    for (int i = 0; i < 2; i++) chk_hs(3 + i, 0, 16'h0200 + 16'(i), i == 1);
    for (int i = 0; i < 3; i++) chk_hs(5 + i, 1, 16'h1100 + 16'(i), i == 2);

    // 3: 10-cycle TREADY stall mid-packet
    hs.delete();
    arb_mode = 1'b1;
    for (int i = 0; i < 6; i++)
      drive(3'b010, (i == 5) ? 3'b010 : 3'b000, 16'h0, 16'h1300 + 16'(i), 16'h0);
    m_tready = 1'b0;
    idle(10);
    m_tready = 1'b1;
    idle(10);
    chk("t3_count", hs.size(), 6);
    for (int i = 0; i < 6; i++) chk_hs(i, 1, 16'h1300 + 16'(i), i == 5);
    chk_gap("t3_stall", 3, 4, 11);

    // 4: overflow of a 12-beat packet into an 8-deep FIFO
    hs.delete();
    m_tready = 1'b0;
    for (int i = 0; i < 12; i++)
      drive(3'b010, (i == 11) ? 3'b010 : 3'b000, 16'h0, 16'h1400 + 16'(i), 16'h0);
    idle(1);
    chk("t4_ovf_set", ovf, 3'b010);
    m_tready = 1'b1;
    idle(12);
    for (int i = 0; i < 3; i++)
      drive(3'b010, (i == 2) ? 3'b010 : 3'b000, 16'h0, 16'h1500 + 16'(i), 16'h0);
    idle(8);
    chk("t4_count", hs.size(), 11);
    for (int i = 0; i < 8; i++) chk_hs(i, 1, 16'h1400 + 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) chk_hs(8 + i, 1, 16'h1500 + 16'(i), i == 2);
    chk("t4_ovf_held", ovf, 3'b010);
    ovf_clr = 3'b010;
    tick();
    ovf_clr = '0;
    idle(1);
    chk("t4_ovf_clr", ovf, 3'b000);

    // 5: suppress ch0 while ch0 and ch1 both pending
    hs.delete();
    suppress = 3'b001;
    for (int i = 0; i < 2; i++)
      drive(3'b011, (i == 1) ? 3'b011 : 3'b000, 16'h0600 + 16'(i), 16'h1600 + 16'(i), 16'h0);
    idle(10);
    chk("t5_sup_count", hs.size(), 2);
    chk_hs(0, 1, 16'h1600, 1'b0);
    chk_hs(1, 1, 16'h1601, 1'b1);
    suppress = '0;
    idle(10);
    chk("t5_count", hs.size(), 4);
    chk_hs(2, 0, 16'h0600, 1'b0);
    chk_hs(3, 0, 16'h0601, 1'b1);

    // 6: one-cycle reset mid-packet
    for (int i = 0; i < 3; i++)
      drive(3'b110, 3'b000, 16'h0, 16'h1700 + 16'(i), 16'h2700 + 16'(i));
    s_tvalid = '0;
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("t6_tvalid_after_rst", m_tvalid, 0);
    chk("t6_ovf_after_rst", ovf, 0);
    hs.delete();
    drive(3'b111, 3'b111, 16'h0800, 16'h1800, 16'h2800);
    idle(12);
    chk("t6_count", hs.size(), 3);
    chk_hs(0, 0, 16'h0800, 1'b1);
    chk_hs(1, 1, 16'h1800, 1'b1);
    chk_hs(2, 2, 16'h2800, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
